fff_round_ctrl: RTL

- Round controller for the four-player fastest-finger-first buzzer.
- Host arms a round. The block synchronises and edge-detects the four raw player buttons, locks out all players after the first valid press, and drives the 7-segment digit and per-player decimal-point lamps.
- Also handles false starts (fouls), simultaneous presses and a no-answer timeout.

---
 rtl/fff_pkg.sv | 37 +++
 rtl/fff_seg_decode.sv | 29 ++
 rtl/fff_round_ctrl.sv | 129 ++++++++++++
 3 files changed

// File: rtl/fff_pkg.sv
// Shared types and constants for the fastest-finger-first round controller:
// FSM state encoding, 7-segment codes and the tie-break helper.
`timescale 1ns/1ps
package fff_pkg;

  localparam int NUM_PLAYERS = 4;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    ARMED   = 2'd1,
    LOCKED  = 2'd2,
    TIMEOUT = 2'd3
  } state_t;

  // Segment order is {a,b,c,d,e,f,g}, active-high.
  localparam logic [6:0] SEG_BLANK = 7'b0000000;
  localparam logic [6:0] SEG_DASH  = 7'b0000001;
  localparam logic [1:4][6:0] SEG_DIGIT = {
    7'b0110000,  // 1
    7'b1101101,  // 2
    7'b1111001,  // 3
    7'b0110011   // 4
  };

  // First eligible player at or after ptr, wrapping 3 -> 0. Scanning from the
  // far end down means the last hit written is the nearest one to ptr.
  function automatic logic [1:0] pick_winner(input logic [NUM_PLAYERS-1:0] elig,
                                             input logic [1:0] ptr);
    logic [1:0] idx;
    pick_winner = ptr;
    for (int k = NUM_PLAYERS - 1; k >= 0; k--) begin
      idx = ptr + 2'(k);
      if (elig[idx]) pick_winner = idx;
    end
  endfunction

endpackage

// File: rtl/fff_seg_decode.sv
// Combinational 7-segment decode: dash for a timed-out round, the winner's
// digit (index 0..3 shown as 1..4) while locked, blank otherwise.
`timescale 1ns/1ps
module fff_seg_decode
  import fff_pkg::*;
(
  input  logic [1:0] idx,
  input  logic       valid,
  input  logic       dash,
  output logic [6:0] seg
);

  // Dash overrides the digit; blank when neither flag is set.
  always_comb begin
    // NOTE: assigning a default first keeps every path driven, so no latch is inferred.
    seg = SEG_BLANK;
    if (dash) begin
      seg = SEG_DASH;
    end else if (valid) begin
      case (idx)
        2'd0:    seg = SEG_DIGIT[1];
        2'd1:    seg = SEG_DIGIT[2];
        2'd2:    seg = SEG_DIGIT[3];
        default: seg = SEG_DIGIT[4];
      endcase
    end
  end

endmodule

// File: rtl/fff_round_ctrl.sv
// Four-player fastest-finger-first round controller. Raw buttons are
// synchronised, edge-detected and registered (press lands 2 edges after the
// raw sample, the FSM acts one edge later). Presses in IDLE are fouls; the
// first eligible press in ARMED locks the round; no press within
// TIMEOUT_CYCLES ends it with a dash.
// Optional: define FFF_ROUND_ROBIN_TIE_EN for a rotating tie-break pointer;
// otherwise the lowest player index wins ties.
`timescale 1ns/1ps
module fff_round_ctrl
  import fff_pkg::*;
#(
  parameter int TIMEOUT_CYCLES = 1000,
  parameter int CNT_W          = 16
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   start,
  input  logic                   clear,
  input  logic [NUM_PLAYERS-1:0] player,
  output logic [6:0]             display,
  output logic [NUM_PLAYERS-1:0] decimal,
  output logic [1:0]             winner_idx,
  output logic                   locked,
  output logic                   armed,
  output logic                   timed_out,
  output logic [NUM_PLAYERS-1:0] foul
);

  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT_CYCLES - 1);

  logic [NUM_PLAYERS-1:0] sync_a, sync, sync_d, press, eligible;
  logic [NUM_PLAYERS-1:0] foul_n;
  logic [CNT_W-1:0]       cnt, cnt_n;
  logic [1:0]             win_n;
  logic [1:0]             ptr;
  state_t                 state, state_n;

  // Two-flop synchroniser, edge history and registered rising-edge pulse.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sync_a <= '0;
      sync   <= '0;
      sync_d <= '0;
      press  <= '0;
    end else begin
      // NOTE: non-blocking assignments make each flop take the previous stage's old value.
      sync_a <= player;
      sync   <= sync_a;
      sync_d <= sync;
      press  <= sync & ~sync_d;
    end
  end

  // Players fouled this round cannot win it.
  assign eligible = press & ~foul;

`ifdef FFF_ROUND_ROBIN_TIE_EN
  // Tie-break pointer moves past each new winner.
  always_ff @(posedge clk or posedge rst) begin
    if (rst)                                   ptr <= 2'd0;
    else if (state == ARMED && state_n == LOCKED) ptr <= win_n + 2'd1;
  end
`else
  assign ptr = 2'd0;
`endif

  // Round state, timeout counter, fouls and winner.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state      <= IDLE;
      cnt        <= '0;
      foul       <= '0;
      winner_idx <= 2'd0;
    end else begin
      state      <= state_n;
      cnt        <= cnt_n;
      foul       <= foul_n;
      winner_idx <= win_n;
    end
  end

  // Next-state logic; clear beats start and any press in the same cycle.
  always_comb begin
    state_n = state;
    cnt_n   = cnt;
    foul_n  = foul;
    win_n   = winner_idx;
    if (clear) begin
      state_n = IDLE;
      cnt_n   = '0;
      foul_n  = '0;
      win_n   = 2'd0;
    end else begin
      case (state)
        IDLE: begin
          foul_n = foul | press;
          if (start) begin
            state_n = ARMED;
            cnt_n   = '0;
          end
        end
        ARMED: begin
          if (eligible != '0) begin
            state_n = LOCKED;
            win_n   = pick_winner(eligible, ptr);
          end else if (cnt == CNT_LAST) begin
            state_n = TIMEOUT;
          end else begin
            cnt_n = cnt + CNT_W'(1);
          end
        end
        default: ;  // LOCKED and TIMEOUT hold until clear
      endcase
    end
  end

  assign locked    = (state == LOCKED);
  assign armed     = (state == ARMED);
  assign timed_out = (state == TIMEOUT);
  assign decimal   = locked ? (NUM_PLAYERS'(1) << winner_idx) : '0;

  fff_seg_decode u_seg (
    .idx   (winner_idx),
    .valid (locked),
    .dash  (timed_out),
    .seg   (display)
  );

endmodule
